lcd_busy_reader: RTL and testbench

LCD_BUSY_READER -- requirements
Module: lcd_busy_reader

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_busy_reader.sv | 178 +++++++++++++++++
 tb/tb_lcd_busy_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus controllers: read-side FSM states,
// default timing, busy-flag position and the RS/RW line encodings.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK,
        DONE
    } lcd_state_t;

    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_PULSE   = 12;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_MAX_POLLS = 255;

    localparam int BUSY_BIT = 7;

    // RS selects instruction vs data register; RW selects read vs write.
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; last is high on the final cycle of a timed phase.
// Loading N-1 makes the phase that follows the load last exactly N cycles.
module lcd_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/lcd_busy_reader.sv
// Polls the LCD busy flag with instruction-register read cycles until the
// panel reports not-busy or the poll budget is exhausted.
module lcd_busy_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_PULSE   = DEF_T_PULSE,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int MAX_POLLS = DEF_MAX_POLLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] db_in,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic       bus_own,
    output logic       done,
    output logic       ready,
    output logic       timeout,
    output logic [6:0] addr
);

    localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
    localparam int TW = $clog2(T_MAX + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);

    localparam logic [TW-1:0] SETUP_LOAD = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(T_PULSE - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(T_HOLD - 1);

    lcd_state_t    state;
    lcd_state_t    next_state;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          phase_last;
    logic [PW-1:0] poll_cnt;
    logic [PW-1:0] poll_inc;
    logic          poll_clr;
    logic          poll_step;
    logic          capture;
    logic          busy_cap;
    logic          next_reading;
    logic          rw_q;
    logic          e_q;
    logic          bus_q;
    logic          done_q;
    logic          ready_q;
    logic          timeout_q;
    logic [6:0]    addr_q;

    lcd_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .last      (phase_last)
    );

    assign poll_inc     = poll_cnt + PW'(1);
    assign next_reading = (next_state inside {SETUP, PULSE, HOLD, CHECK});

    // The timer is reloaded on the cycle that leaves a phase, so the next
    // phase starts with its full count.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        poll_clr    = 1'b0;
        poll_step   = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state  = SETUP;
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                    poll_clr    = 1'b1;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    next_state  = PULSE;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (phase_last) begin
                    next_state  = HOLD;
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                    capture     = 1'b1;
                end
            end
            HOLD: begin
                if (phase_last) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (!busy_cap) begin
                    next_state = DONE;
                end else begin
                    poll_step = 1'b1;
                    if (poll_inc == PW'(MAX_POLLS)) begin
                        next_state = DONE;
                    end else begin
                        next_state  = SETUP;
                        timer_load  = 1'b1;
                        timer_value = SETUP_LOAD;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so e never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            e_q    <= 1'b0;
            rw_q   <= RW_WRITE;
            bus_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            e_q    <= (next_state == PULSE);
            rw_q   <= next_reading ? RW_READ : RW_WRITE;
            bus_q  <= next_reading;
            done_q <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt  <= '0;
            busy_cap  <= 1'b0;
            addr_q    <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (poll_clr) begin
                poll_cnt <= '0;
            end else if (poll_step) begin
                poll_cnt <= poll_inc;
            end
            if (capture) begin
                busy_cap <= db_in[BUSY_BIT];
                addr_q   <= db_in[6:0];
            end
            if (state == CHECK && next_state == DONE) begin
                ready_q   <= ~busy_cap;
                timeout_q <= busy_cap;
            end
        end
    end

    assign rs      = RS_INSTR;
    assign rw      = rw_q;
    assign e       = e_q;
    assign bus_own = bus_q;
    assign done    = done_q;
    assign ready   = ready_q;
    assign timeout = timeout_q;
    assign addr    = addr_q;

endmodule

// File: tb/tb_lcd_busy_reader.sv
// Scoreboard bench: three differently parameterised readers, one active at a
// time, with an LCD responder feeding one queued byte per read strobe.
module tb_lcd_busy_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    logic [7:0] db_in;
    logic [2:0] rs_v, rw_v, e_v, bus_v, done_v, ready_v, to_v;
    logic [6:0] addr_v [3];

    lcd_busy_reader u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .db_in(db_in),
        .rs(rs_v[0]), .rw(rw_v[0]), .e(e_v[0]), .bus_own(bus_v[0]),
        .done(done_v[0]), .ready(ready_v[0]), .timeout(to_v[0]), .addr(addr_v[0])
    );

    lcd_busy_reader #(.MAX_POLLS(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .db_in(db_in),
        .rs(rs_v[1]), .rw(rw_v[1]), .e(e_v[1]), .bus_own(bus_v[1]),
        .done(done_v[1]), .ready(ready_v[1]), .timeout(to_v[1]), .addr(addr_v[1])
    );

    lcd_busy_reader #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .db_in(db_in),
        .rs(rs_v[2]), .rw(rw_v[2]), .e(e_v[2]), .bus_own(bus_v[2]),
        .done(done_v[2]), .ready(ready_v[2]), .timeout(to_v[2]), .addr(addr_v[2])
    );

    localparam int TS [3] = '{2, 2, 1};
    localparam int TP [3] = '{12, 12, 1};
    localparam int TH [3] = '{2, 2, 1};
    localparam int MP [3] = '{255, 4, 255};

    typedef struct {
        int         done_cyc;
        int         first_rise;
        int         pulses;
        logic       ready;
        logic       timeout;
        logic [6:0] addr;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] req_q [$];
    logic [7:0] lcd_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int active = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: polls run until a not-busy byte or the budget; each poll is
    // one setup+pulse+hold+check period, plus the start cycle and DONE.
    task automatic computeExpected(input int inst, input int n, input int base,
                                   output exp_t x, output int used);
        int polls = 0;
        logic busy = 1'b1;
        logic [7:0] val = 8'h00;
        int per;
        while (busy && polls < MP[inst]) begin
            val = (base + polls < req_q.size()) ? req_q[base + polls] : 8'h00;
            polls++;
            busy = val[7];
        end
        per = TS[inst] + TP[inst] + TH[inst] + 1;
        x.done_cyc   = n + per + 1 + (polls - 1) * per;
        x.first_rise = n + TS[inst] + 1;
        x.pulses     = polls;
        x.ready      = ~busy;
        x.timeout    = busy;
        x.addr       = val[6:0];
        used         = polls;
    endtask

    task automatic waitIdle();
        int k = 0;
        while (sb.size() != 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checkOutput("done_wait", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input int inst);
        exp_t x;
        int used;
        waitIdle();
        @(negedge clk);
        active = inst;
        lcd_q = req_q;
        computeExpected(inst, cyc, 0, x, used);
        sb.push_back(x);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
    endtask

    // LCD responder: advance to the next byte once a read strobe has ended.
    bit lcd_eprev = 1'b0;
    always @(negedge clk) begin
        if (lcd_eprev && !e_v[active] && lcd_q.size() > 0) lcd_q.delete(0);
        lcd_eprev = e_v[active];
        db_in = (lcd_q.size() > 0) ? lcd_q[0] : 8'h00;
    end

    bit e_prev = 1'b0;
    int run = 0;
    int pulses = 0;
    int first_rise = 0;
    always @(negedge clk) begin
        exp_t x;
        logic [2:0] others;
        if (rst) begin
            e_prev = 1'b0;
            run    = 0;
            pulses = 0;
        end else begin
            if (e_v[active] === 1'b1) begin
                if (!e_prev) begin
                    pulses++;
                    if (pulses == 1) first_rise = cyc;
                end
                run++;
                checkOutput("rw_during_e", rw_v[active], 1);
                checkOutput("bus_during_e", bus_v[active], 1);
            end else if (e_prev) begin
                checkOutput("e_width", run, TP[active]);
                run = 0;
            end
            e_prev = (e_v[active] === 1'b1);
        end
        others = done_v & ~(3'b001 << active);
        if (|others) checkOutput("inactive_done", others, 0);
        if (done_v[active] === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                x = sb.pop_front();
                checkOutput("done_cycle", cyc, x.done_cyc);
                checkOutput("first_e_cycle", first_rise, x.first_rise);
                checkOutput("e_pulses", pulses, x.pulses);
                checkOutput("ready", ready_v[active], x.ready);
                checkOutput("timeout", to_v[active], x.timeout);
                checkOutput("addr", addr_v[active], x.addr);
                checkOutput("rw_at_done", rw_v[active], 0);
                checkOutput("bus_at_done", bus_v[active], 0);
                checkOutput("rs_at_done", rs_v[active], 0);
            end
            pulses = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t x1, x2;
        int u1, u2, n, b, inst;
        rst = 1'b1;
        start_v = 3'b000;
        db_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_e", e_v[0], 0);
        checkOutput("rst_rw", rw_v[0], 0);
        checkOutput("rst_bus", bus_v[0], 0);
        checkOutput("rst_ready", ready_v[0], 0);
        checkOutput("rst_timeout", to_v[0], 0);
        checkOutput("rst_addr", addr_v[0], 0);
        checkOutput("rst_done_all", done_v, 0);
        rst = 1'b0;

        req_q = '{8'h05};
        applyStimulus(0);
        req_q = '{8'h80, 8'h80, 8'h80, 8'h12};
        applyStimulus(0);
        req_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        applyStimulus(1);
        req_q = '{8'h05};
        applyStimulus(2);

        // Reset in the middle of the strobe after a successful request.
        req_q = '{8'h33};
        applyStimulus(0);
        waitIdle();
        @(negedge clk);
        n = cyc;
        lcd_q = req_q;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("pre_rst_e", e_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_cycle", cyc, n + 9);
        checkOutput("mid_rst_e", e_v[0], 0);
        checkOutput("mid_rst_bus", bus_v[0], 0);
        checkOutput("mid_rst_rw", rw_v[0], 0);
        checkOutput("mid_rst_done", done_v[0], 0);
        checkOutput("mid_rst_ready", ready_v[0], 0);
        checkOutput("mid_rst_timeout", to_v[0], 0);
        checkOutput("mid_rst_addr", addr_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("post_rst_e", e_v[0], 0);

        // Start re-pulsed inside the strobe must be ignored.
        req_q = '{8'h44};
        applyStimulus(0);
        repeat (5) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        waitIdle();
        repeat (20) @(negedge clk);

        // Start held high: back-to-back requests with one IDLE cycle between.
        req_q = '{8'h80, 8'h21, 8'h09};
        waitIdle();
        @(negedge clk);
        active = 0;
        lcd_q = req_q;
        computeExpected(0, cyc, 0, x1, u1);
        computeExpected(0, x1.done_cyc + 1, u1, x2, u2);
        sb.push_back(x1);
        sb.push_back(x2);
        start_v[0] = 1'b1;
        while (cyc < x2.done_cyc) @(negedge clk);
        start_v[0] = 1'b0;
        waitIdle();
        repeat (25) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            inst = $urandom_range(0, 2);
            b = (inst == 1) ? $urandom_range(0, 6) : $urandom_range(0, 3);
            req_q.delete();
            for (int j = 0; j < b; j++) req_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
            req_q.push_back(8'($urandom_range(0, 127)));
            applyStimulus(inst);
        end

        waitIdle();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
